ud_mod_counter: RTL and testbench

//   Parametrised modulo-N up/down counter; successor to the fixed mod-12 4-bit up/down counter.

---
 rtl/ud_mod_counter.sv | 100 ++++++++++
 tb/tb_ud_mod_counter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/ud_mod_counter.sv
// Parametrised modulo-N up/down counter with load, programmable step and wrap/saturate mode.
// Latency: Count, wrap and err update one Clk edge after inputs are sampled; tc is combinational.
// Backpressure: none; en gates counting, and a load takes precedence over counting.
module ud_mod_counter #(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 12,
  parameter int SATURATE = 0
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             en,
  input  logic             UpOrDown,
  input  logic [WIDTH-1:0] step,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] Count,
  output logic             tc,
  output logic             wrap,
  output logic             err
);

  // Modulus widened by one bit, so that MODULUS == 2**WIDTH can be represented
  localparam logic [WIDTH:0]   MOD_X = (WIDTH+1)'(MODULUS);
  // Modulus reduced mod 2**WIDTH; it is used only in wrap arithmetic whose true result is < MODULUS
  localparam logic [WIDTH-1:0] MOD_W = WIDTH'(MODULUS);
  // Largest legal count value
  localparam logic [WIDTH-1:0] TOP   = WIDTH'(MODULUS - 1);

  // Reject moduli that cannot be represented or that make no sense as a counter
  if ((MODULUS < 2) || (longint'(MODULUS) > (longint'(1) << WIDTH))) begin : g_param_check
    $error("ud_mod_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
  end

  logic [WIDTH:0]   cnt_x;
  logic [WIDTH:0]   step_x;
  logic [WIDTH:0]   load_x;
  logic [WIDTH:0]   sum_x;
  logic [WIDTH-1:0] count_nxt;
  logic             wrap_nxt;
  logic             err_nxt;

  // Next-state decode, with priority load > en > hold
  always_comb begin
    cnt_x     = {1'b0, Count};
    step_x    = {1'b0, step};
    load_x    = {1'b0, load_val};
    sum_x     = cnt_x + step_x;
    count_nxt = Count;
    wrap_nxt  = 1'b0;
    err_nxt   = 1'b0;
    if (load) begin
      if (load_x < MOD_X) begin
        count_nxt = load_val;
      end else begin
        // An out-of-range load lands on the top value, so Count stays legal
        count_nxt = TOP;
        err_nxt   = 1'b1;
      end
    end else if (en) begin
      if (step_x == '0) begin
        count_nxt = Count;
      end else if (step_x >= MOD_X) begin
        // A step of a full modulus or more is flagged and ignored
        err_nxt = 1'b1;
      end else if (UpOrDown) begin
        if (sum_x < MOD_X) begin
          count_nxt = sum_x[WIDTH-1:0];
        end else begin
          wrap_nxt  = 1'b1;
          // Modulo-2**WIDTH arithmetic is exact here because the result is < MODULUS
          count_nxt = (SATURATE != 0) ? TOP : (Count + step - MOD_W);
        end
      end else begin
        if (cnt_x >= step_x) begin
          count_nxt = Count - step;
        end else begin
          wrap_nxt  = 1'b1;
          count_nxt = (SATURATE != 0) ? '0 : (Count + MOD_W - step);
        end
      end
    end
  end

  // State and event-pulse registers, with asynchronous clear
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      Count <= '0;
      wrap  <= 1'b0;
      err   <= 1'b0;
    end else begin
      Count <= count_nxt;
      wrap  <= wrap_nxt;
      err   <= err_nxt;
    end
  end

  // Terminal count follows the current direction, so cascaded stages see it at once
  assign tc = UpOrDown ? (Count == TOP) : (Count == '0);

endmodule

// File: tb/tb_ud_mod_counter.sv
module tb_ud_mod_counter;

  logic       Clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic       UpOrDown = 1'b1;
  logic [3:0] step = '0;
  logic       load = 1'b0;
  logic [3:0] load_val = '0;

  logic [3:0] cnt_o [3];
  logic       tc_o  [3];
  logic       wrap_o[3];
  logic       err_o [3];

  // Three flavours share the stimulus: mod-12 wrap, mod-12 saturate, full-range mod-16 wrap
  ud_mod_counter #(.WIDTH(4), .MODULUS(12), .SATURATE(0)) u_wrap (
    .Clk(Clk), .reset(reset), .en(en), .UpOrDown(UpOrDown), .step(step), .load(load),
    .load_val(load_val), .Count(cnt_o[0]), .tc(tc_o[0]), .wrap(wrap_o[0]), .err(err_o[0]));
  ud_mod_counter #(.WIDTH(4), .MODULUS(12), .SATURATE(1)) u_sat (
    .Clk(Clk), .reset(reset), .en(en), .UpOrDown(UpOrDown), .step(step), .load(load),
    .load_val(load_val), .Count(cnt_o[1]), .tc(tc_o[1]), .wrap(wrap_o[1]), .err(err_o[1]));
  ud_mod_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(0)) u_full (
    .Clk(Clk), .reset(reset), .en(en), .UpOrDown(UpOrDown), .step(step), .load(load),
    .load_val(load_val), .Count(cnt_o[2]), .tc(tc_o[2]), .wrap(wrap_o[2]), .err(err_o[2]));

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [4:0] cnt;
    logic       w;
    logic       e;
  } exp_t;
  typedef exp_t [2:0] trio_t;

  int    mods[3] = '{12, 12, 16};
  bit    sats[3] = '{1'b0, 1'b1, 1'b0};
  int    mc[3]   = '{0, 0, 0};
  trio_t sbq[$];
  trio_t mon_t;
  int    tests = 0;
  int    fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the counting rules expressed with plain integer arithmetic
  function automatic void model(input int m, input bit sat, input int c, input bit l,
                                input int lv, input bit e, input bit ud, input int st,
                                output int nc, output bit w, output bit er);
    nc = c; w = 1'b0; er = 1'b0;
    if (l) begin
      if (lv < m) nc = lv;
      else begin nc = m - 1; er = 1'b1; end
    end else if (e) begin
      if (st >= m) er = 1'b1;
      else if (st != 0) begin
        int v;
        v = ud ? c + st : c - st;
        if (v >= m)     begin w = 1'b1; nc = sat ? m - 1 : v - m; end
        else if (v < 0) begin w = 1'b1; nc = sat ? 0 : v + m; end
        else nc = v;
      end
    end
  endfunction

  // Drive one cycle of inputs at the falling edge and queue the expected result of the next rise
  task automatic drive(input bit l, input int lv, input bit e, input bit ud, input int st);
    trio_t t;
    int    nc;
    bit    w, er;
    @(negedge Clk);
    load = l; load_val = 4'(lv); en = e; UpOrDown = ud; step = 4'(st);
    for (int i = 0; i < 3; i++) begin
      model(mods[i], sats[i], mc[i], l, lv, e, ud, st, nc, w, er);
      mc[i]    = nc;
      t[i].cnt = 5'(nc);
      t[i].w   = w;
      t[i].e   = er;
    end
    sbq.push_back(t);
  endtask

  // Monitor: after every rising edge out of reset, compare outputs with the oldest expectation
  always @(posedge Clk) begin
    #1;
    if (reset && sbq.size() > 0) begin
      mon_t = sbq.pop_front();
      for (int i = 0; i < 3; i++) begin
        check($sformatf("count[%0d]", i), 32'(cnt_o[i]), 32'(mon_t[i].cnt));
        check($sformatf("wrap[%0d]", i), 32'(wrap_o[i]), 32'(mon_t[i].w));
        check($sformatf("err[%0d]", i), 32'(err_o[i]), 32'(mon_t[i].e));
        check($sformatf("tc[%0d]", i), 32'(tc_o[i]),
              32'(UpOrDown ? (mon_t[i].cnt == 5'(mods[i] - 1)) : (mon_t[i].cnt == 5'd0)));
      end
    end
  end

  initial begin
    int r, st;
    #2;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_count[%0d]", i), 32'(cnt_o[i]), 0);
      check($sformatf("rst_wrap[%0d]", i), 32'(wrap_o[i]), 0);
      check($sformatf("rst_err[%0d]", i), 32'(err_o[i]), 0);
    end
    @(negedge Clk);
    reset = 1'b1;

    // Count up by one from 0 for 14 cycles, then down by one for 14 cycles
    drive(1, 0, 0, 1, 0);
    for (int k = 0; k < 14; k++) drive(0, 0, 1, 1, 1);
    drive(1, 0, 0, 0, 0);
    for (int k = 0; k < 14; k++) drive(0, 0, 1, 0, 1);

    // Step 5 across the boundary in both directions
    drive(1, 9, 0, 1, 0);
    drive(0, 0, 1, 1, 5);
    drive(0, 0, 1, 0, 5);

    // Saturation at the top, twice in a row
    drive(1, 10, 0, 1, 0);
    drive(0, 0, 1, 1, 3);
    drive(0, 0, 1, 1, 3);

    // Load wins over en; out-of-range load; illegal step; back-to-back errors
    drive(1, 7, 1, 1, 3);
    drive(1, 13, 1, 1, 1);
    drive(0, 0, 1, 1, 12);
    drive(0, 0, 1, 0, 15);
    drive(1, 15, 0, 1, 0);
    drive(0, 0, 0, 1, 0);

    // tc follows a change of UpOrDown in the middle of a cycle
    drive(1, 11, 0, 1, 0);
    drive(0, 0, 0, 1, 0);
    @(posedge Clk);
    #3;
    UpOrDown = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) check($sformatf("tc_mid_dn[%0d]", i), 32'(tc_o[i]), 32'(mc[i] == 0));
    UpOrDown = 1'b1;
    #1;
    for (int i = 0; i < 3; i++)
      check($sformatf("tc_mid_up[%0d]", i), 32'(tc_o[i]), 32'(mc[i] == mods[i] - 1));

    // Randomised traffic
    for (int k = 0; k < 400; k++) begin
      r  = $urandom_range(0, 9);
      st = (r < 6) ? $urandom_range(1, 4) : $urandom_range(0, 15);
      drive($urandom_range(0, 7) == 0, $urandom_range(0, 15), $urandom_range(0, 3) != 0,
            $urandom_range(0, 1) == 1, st);
    end

    // Asynchronous reset in the middle of counting, while an err pulse is active
    drive(1, 6, 0, 1, 0);
    drive(0, 0, 1, 1, 12);
    @(posedge Clk);
    #3;
    reset = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("async_count[%0d]", i), 32'(cnt_o[i]), 0);
      check($sformatf("async_wrap[%0d]", i), 32'(wrap_o[i]), 0);
      check($sformatf("async_err[%0d]", i), 32'(err_o[i]), 0);
      mc[i] = 0;
    end
    @(negedge Clk);
    load = 1'b0; en = 1'b1; step = 4'd1;
    @(negedge Clk);
    for (int i = 0; i < 3; i++) check($sformatf("held_rst_count[%0d]", i), 32'(cnt_o[i]), 0);
    reset = 1'b1;
    en = 1'b0;
    for (int k = 0; k < 5; k++) drive(0, 0, 1, 1, 1);
    for (int k = 0; k < 60; k++)
      drive($urandom_range(0, 7) == 0, $urandom_range(0, 15), 1'b1,
            $urandom_range(0, 1) == 1, $urandom_range(0, 15));

    @(posedge Clk);
    #3;
    check("scoreboard_drained", 32'(sbq.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
